// File: rtl/tt_mux_pkg.sv
// tt_mux_pkg
// Shared definitions for the project-multiplexer address/enable controller.
//   DEF_ADDR_W        default width of the mux address bus
//   DEF_NUM_PROJECTS  default number of selectable projects
//   mux_ctrl_state_t  enable FSM states (OFF, SETTLE, ON)
package tt_mux_pkg;

  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_NUM_PROJECTS = 24;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    ON     = 2'd2
  } mux_ctrl_state_t;

endpackage

// File: rtl/tt_sync2.sv
// tt_sync2
// Two-flop synchronizer for a single slow control pin.
// Parameters:
//   RESET_VAL  value both flops take while rst_n is low
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input pin
//   q      out  synchronized copy of d, two clocks later
module tt_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/tt_mux_ctrl.sv
// tt_mux_ctrl
// Turns the select-reset, select-increment and global-enable pins into the
// project mux address and enable. After every address change (or enable
// rise) the enable is held low for GUARD_CYCLES clocks so a newly selected
// project is never enabled while its gated inputs settle.
// Build option:
//   TT_MUX_CTRL_SYNC_EN  defined: each pin passes through a 2-flop
//                        synchronizer (+2 clocks latency); undefined: pins
//                        are assumed already synchronous to clk.
// Parameters:
//   NUM_PROJECTS  number of selectable projects (address wraps after N-1)
//   ADDR_W        address width, NUM_PROJECTS <= 2**ADDR_W
//   GUARD_CYCLES  clocks ena stays low after a change; 0 disables the guard
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sel_rst_n  in   low forces address 0 and disables
//   sel_inc    in   each rising edge advances the address by one
//   sel_ena    in   high requests the selected project be enabled
//   addr       out  registered project address
//   ena        out  registered project enable
//   busy       out  high while the guard window is running
module tt_mux_ctrl
  import tt_mux_pkg::*;
#(
  parameter int NUM_PROJECTS = DEF_NUM_PROJECTS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int GUARD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_rst_n,
  input  logic              sel_inc,
  input  logic              sel_ena,
  output logic [ADDR_W-1:0] addr,
  output logic              ena,
  output logic              busy
);

  localparam int GCNT_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [GCNT_W-1:0] GUARD_LOAD = GCNT_W'(GUARD_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_PROJECTS - 1);

  // Conditioned inputs, bit order {sel_rst_n, sel_inc, sel_ena}
  logic [2:0] pins;
  logic [2:0] cond;
  logic       s_rst_n;
  logic       s_inc;
  logic       s_ena;

  assign pins = {sel_rst_n, sel_inc, sel_ena};

`ifdef TT_MUX_CTRL_SYNC_EN
  // All chains reset to 0; for sel_rst_n that means "held in select reset"
  // until the pin has been seen high through the synchronizer.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    tt_sync2 #(
      .RESET_VAL(1'b0)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (pins[gi]),
      .q    (cond[gi])
    );
  end
`else
  assign cond = pins;
`endif

  assign s_rst_n = cond[2];
  assign s_inc   = cond[1];
  assign s_ena   = cond[0];

  // Increment edge detector. inc_prev resets high so a pin already high at
  // reset release is not mistaken for a fresh rising edge.
  logic inc_prev_reg;
  logic inc_pulse;

  assign inc_pulse = s_inc & ~inc_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_prev_reg <= 1'b1;
    end else begin
      inc_prev_reg <= s_inc;
    end
  end

  // Address register; select reset wins over (and discards) an increment.
  logic [ADDR_W-1:0] addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
    end else if (!s_rst_n) begin
      addr_reg <= '0;
    end else if (inc_pulse) begin
      addr_reg <= (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_W'(1);
    end
  end

  assign addr = addr_reg;

  // Enable FSM
  mux_ctrl_state_t   state_reg;
  mux_ctrl_state_t   state_next;
  logic [GCNT_W-1:0] gcnt_reg;
  logic [GCNT_W-1:0] gcnt_next;
  logic              ena_reg;
  logic              busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= OFF;
      gcnt_reg  <= '0;
      ena_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      gcnt_reg  <= gcnt_next;
      // Outputs come from dedicated flops so a multi-bit state change
      // cannot glitch the mux enable.
      ena_reg   <= (state_next == ON);
      busy_reg  <= (state_next == SETTLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    gcnt_next  = gcnt_reg;
    if (!s_rst_n || !s_ena) begin
      // Abort has priority over everything, from every state.
      state_next = OFF;
      gcnt_next  = '0;
    end else begin
      case (state_reg)
        OFF: begin
          if (GUARD_CYCLES == 0) begin
            state_next = ON;
          end else begin
            state_next = SETTLE;
            gcnt_next  = GUARD_LOAD;
          end
        end
        SETTLE: begin
          if (inc_pulse) begin
            // Address moved again while settling: restart the window.
            gcnt_next = GUARD_LOAD;
          end else if (gcnt_reg == GCNT_W'(1)) begin
            state_next = ON;
            gcnt_next  = '0;
          end else begin
            gcnt_next = gcnt_reg - GCNT_W'(1);
          end
        end
        ON: begin
          // With no guard an address change keeps the project enabled.
          if (inc_pulse && (GUARD_CYCLES != 0)) begin
            state_next = SETTLE;
            gcnt_next  = GUARD_LOAD;
          end
        end
        default: begin
          state_next = OFF;
          gcnt_next  = '0;
        end
      endcase
    end
  end

  assign ena  = ena_reg;
  assign busy = busy_reg;

endmodule
